corescore_axis2atlantic: RTL and testbench
==========================================

Name: corescore_axis2atlantic

Overview:
Buffering adapter between the corescorecore byte stream (AXI-Stream style: tdata/tlast/tvalid/tready) and the JTAG-Atlantic UART transmit port (r_dat/r_val/r_ena).
- Decouples the cores from the host-paced JTAG link with a small FIFO.
- Enforces the UART rule that a byte is presented only in the cycle after r_ena was sampled high.
- Optionally appends an end-of-line byte after every tlast.
- Counts completed frames for debug.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries of {tlast,tdata}; legal range 1..8.
APPEND_EOL, 0, 1 = emit EOL_CHAR after each byte tagged tlast.
EOL_CHAR, 8'h0A, byte inserted when APPEND_EOL=1.

Ports:
i_clk      in   1   system clock (16 MHz PLL output)
i_rst_n    in   1   synchronous active-low reset
i_tdata    in   8   stream byte from corescorecore
i_tlast    in   1   last byte of a core message
i_tvalid   in   1   stream valid
o_tready   out  1   stream ready
i_r_ena    in   1   UART can accept a byte next cycle
o_r_dat    out  8   byte to UART
o_r_val    out  1   byte strobe to UART; one byte transferred per cycle high
o_frames   out  16  count of tlast bytes delivered to UART, wraps

Behaviour:
- Reset: i_rst_n low, sampled on rising i_clk.
  - FIFO count=0; rd/wr pointers=0; state=S_DATA.
  - o_r_val=0, o_r_dat=8'h00, o_frames=0.
  - o_tready=0 while i_rst_n low; otherwise o_tready = !full (combinational from count).
- Input push: i_tvalid & o_tready at an edge writes {i_tlast,i_tdata} at wr_ptr; wr_ptr+1 mod depth; count+1.
  - Full: o_tready=0, no write, stream stalls losslessly.
  - No bypass: a byte written at edge k is readable from cycle k+1 onward.
- Output FSM (all outputs registered):
  - S_DATA:
    - If i_r_ena & !empty at the edge: o_r_val<=1, o_r_dat<=head.data, pop.
    - If additionally head.tlast: o_frames<=o_frames+1.
    - If head.tlast and APPEND_EOL=1: next state S_EOL.
    - Otherwise o_r_val<=0 and o_r_dat holds its value.
  - S_EOL:
    - If i_r_ena: o_r_val<=1, o_r_dat<=EOL_CHAR, next state S_DATA.
    - Else o_r_val<=0, stay in S_EOL. FIFO is not popped in S_EOL.
  - o_r_val is never high unless i_r_ena was high at the same edge that set it. This is the one-cycle pipeline the UART requires.
- Simultaneous push and pop: allowed when neither full nor empty; count unchanged; both pointers advance.
- Latency:
  - Empty FIFO, i_r_ena constantly high: input handshake at edge k gives o_r_val=1 with that byte after edge k+1.
  - Sustained throughput is 1 byte/cycle while i_r_ena stays high.
- i_r_ena low holds the FIFO contents indefinitely. No drop, no timeout.
- Pointer wrap: pointers are DEPTH_LOG2 bits; full/empty derive from a separate count of DEPTH_LOG2+1 bits.
- o_frames wraps 16'hFFFF -> 16'h0000.
- Reset mid-operation: FIFO contents discarded; a pending EOL is dropped; o_r_val low from the first edge with i_rst_n low.

Decomposition:
- Shared package corescore_pkg holds:
  - the FIFO entry width constant (9);
  - the default EOL byte;
  - a 1-bit output-state enum {S_DATA, S_EOL}.
- One natural sub-module: corescore_sync_fifo.
  - Parameterised width/depth; single clock; synchronous active-low reset.
  - Ports: push/pop/wdata/rdata/full/empty.
  - Head is read combinationally (show-ahead).
- The FSM, output registers and frame counter stay in the top module.

Test Plan:
1. Reset release with i_r_ena=1, push 8'h41 (tlast=0) at edge 2 -> o_r_val=1, o_r_dat=8'h41 after edge 3 only; o_frames=0.
2. i_r_ena=0, push 17 bytes with DEPTH_LOG2=4 -> o_tready drops after the 16th accept; 17th held; raising i_r_ena drains all 17 in order, one per cycle, no gaps.
3. APPEND_EOL=1, push "H","i"(tlast) with i_r_ena=1 -> o_r_dat sequence 8'h48, 8'h69, 8'h0A on consecutive o_r_val cycles; o_frames=1.
4. APPEND_EOL=1, tlast byte popped, then i_r_ena=0 for 5 cycles -> o_r_val=0, FSM held in S_EOL; EOL emitted on the first cycle after i_r_ena returns.
5. Toggle i_r_ena every cycle while streaming 8'h00..8'h1F -> o_r_val only in the cycles after i_r_ena=1; all 32 bytes delivered in order, none duplicated.
6. Assert i_rst_n=0 with 6 bytes buffered and FSM in S_EOL -> next cycle o_r_val=0, o_tready=0, o_frames=0; after release the FIFO is empty and no stale byte appears.

Source files
------------

// File: rtl/corescore_pkg.sv
// Shared types and constants for the corescore stream-to-UART adapter.
package corescore_pkg;

    localparam int unsigned FIFO_W      = 9;
    localparam logic [7:0]  EOL_DEFAULT = 8'h0A;

    typedef enum logic {
        S_DATA = 1'b0,
        S_EOL  = 1'b1
    } out_state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/corescore_sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty come from a count one bit wider than the pointers.
module corescore_sync_fifo #(
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the bookkeeping is cleared.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/corescore_axis2atlantic.sv
// Buffers the core byte stream and paces it onto the JTAG-Atlantic UART,
// optionally following each tagged last byte with an end-of-line byte.
module corescore_axis2atlantic
    import corescore_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter bit          APPEND_EOL = 1'b0,
    parameter logic [7:0]  EOL_CHAR   = EOL_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        o_tready,
    input  logic        i_r_ena,
    output logic [7:0]  o_r_dat,
    output logic        o_r_val,
    output logic [15:0] o_frames
);

    out_state_t        state;
    fifo_entry_t       head;
    logic [FIFO_W-1:0] rdata;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign o_tready = i_rst_n && !full;
    assign push     = i_tvalid && o_tready;
    assign pop      = (state == S_DATA) && i_r_ena && !empty;
    assign head     = fifo_entry_t'(rdata);

    corescore_sync_fifo #(
        .WIDTH      (FIFO_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .pop     (pop),
        .wdata   ({i_tlast, i_tdata}),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty)
    );

    // A byte is only ever strobed out when i_r_ena was seen at the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_DATA;
            o_r_val  <= 1'b0;
            o_r_dat  <= 8'h00;
            o_frames <= 16'h0000;
        end else begin
            o_r_val <= 1'b0;
            case (state)
                S_DATA: begin
                    if (pop) begin
                        o_r_val <= 1'b1;
                        o_r_dat <= head.data;
                        if (head.last) begin
                            o_frames <= o_frames + 16'd1;
                            if (APPEND_EOL) begin
                                state <= S_EOL;
                            end
                        end
                    end
                end
                S_EOL: begin
                    if (i_r_ena) begin
                        o_r_val <= 1'b1;
                        o_r_dat <= EOL_CHAR;
                        state   <= S_DATA;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corescore_axis2atlantic.sv
// Scoreboard bench for corescore_axis2atlantic (DEPTH_LOG2=4, APPEND_EOL=1).
module tb_corescore_axis2atlantic;

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;
    logic        i_r_ena;
    logic [7:0]  o_r_dat;
    logic        o_r_val;
    logic [15:0] o_frames;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    logic [15:0] frames_exp = 16'h0000;
    logic        ena_at_edge = 1'b0;

    always #5 clk = ~clk;

    corescore_axis2atlantic #(
        .DEPTH_LOG2 (4),
        .APPEND_EOL (1'b1),
        .EOL_CHAR   (8'h0A)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (i_rst_n),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .i_r_ena  (i_r_ena),
        .o_r_dat  (o_r_dat),
        .o_r_val  (o_r_val),
        .o_frames (o_frames)
    );

    // Monitor: expectations are queued on each accepted input and retired on each strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_r_val) begin
                tests++;
                if (!ena_at_edge) begin
                    fails++;
                    $display("FAIL strobe_gating: o_r_val=1 but i_r_ena was 0 at the edge");
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %02h, required none", o_r_dat);
                end else begin
                    e = exp_q.pop_front();
                    if (o_r_dat !== e.data) begin
                        fails++;
                        $display("FAIL byte_order: got %02h, required %02h", o_r_dat, e.data);
                    end
                    if (e.last) frames_exp = frames_exp + 16'd1;
                    tests++;
                    if (o_frames !== frames_exp) begin
                        fails++;
                        $display("FAIL frames: got %0d, required %0d", o_frames, frames_exp);
                    end
                end
            end
            ena_at_edge = i_r_ena;
            if (i_tvalid && o_tready && i_rst_n) begin
                exp_q.push_back('{data: i_tdata, last: i_tlast});
                if (i_tlast) exp_q.push_back('{data: 8'h0A, last: 1'b0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Offer one byte and wait (bounded) for its handshake.
    task automatic push_byte(input logic [7:0] d, input logic l);
        bit acc = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = l;
        for (int c = 0; c < 50 && !acc; c++) begin
            acc = o_tready;
            tick();
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        if (!acc) check("push_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        int  sent;
        bit  acc;
        i_rst_n  = 1'b0;
        i_tdata  = 8'h00;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        i_r_ena  = 1'b1;
        tick();
        tick();
        check("rst_val",    32'(o_r_val),  32'd0);
        check("rst_dat",    32'(o_r_dat),  32'h00);
        check("rst_frames", 32'(o_frames), 32'd0);
        check("rst_tready", 32'(o_tready), 32'd0);

        // 1: single byte latency
        i_rst_n  = 1'b1;
        #1;
        check("tready_after_rst", 32'(o_tready), 32'd1);
        i_tvalid = 1'b1;
        i_tdata  = 8'h41;
        tick();
        i_tvalid = 1'b0;
        check("lat_early", 32'(o_r_val), 32'd0);
        tick();
        check("lat_val", 32'(o_r_val), 32'd1);
        check("lat_dat", 32'(o_r_dat), 32'h41);
        check("lat_frames", 32'(o_frames), 32'd0);
        tick();

        // 2: fill with UART stalled, then drain without gaps
        i_r_ena = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), 1'b0);
        check("full_tready", 32'(o_tready), 32'd0);
        i_tvalid = 1'b1;
        i_tdata  = 8'h90;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_hold_tready", 32'(o_tready), 32'd0);
            check("full_hold_val", 32'(o_r_val), 32'd0);
        end
        i_r_ena = 1'b1;
        for (int c = 0; c < 17; c++) begin
            acc = i_tvalid && o_tready;
            tick();
            if (acc) i_tvalid = 1'b0;
            check("drain_no_gap", 32'(o_r_val), 32'd1);
        end
        tick();
        check("drain_done", 32'(o_r_val), 32'd0);

        // 3: "H","i"+tlast with EOL appended
        i_tvalid = 1'b1;
        i_tdata  = 8'h48;
        tick();
        i_tdata  = 8'h69;
        i_tlast  = 1'b1;
        tick();
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        check("hi_h", 32'({o_r_val, o_r_dat}), 32'h148);
        tick();
        check("hi_i", 32'({o_r_val, o_r_dat}), 32'h169);
        tick();
        check("hi_eol", 32'({o_r_val, o_r_dat}), 32'h10A);
        check("hi_frames", 32'(o_frames), 32'd1);
        tick();

        // 4: EOL held while UART stalls
        push_byte(8'h5A, 1'b1);
        tick();
        check("z_val", 32'({o_r_val, o_r_dat}), 32'h15A);
        i_r_ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("eol_stall", 32'(o_r_val), 32'd0);
        end
        i_r_ena = 1'b1;
        tick();
        check("eol_resume", 32'({o_r_val, o_r_dat}), 32'h10A);
        check("z_frames", 32'(o_frames), 32'd2);
        tick();

        // 5: stream 0x00..0x1F with i_r_ena toggling every cycle
        sent     = 0;
        i_r_ena  = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = 8'h00;
        for (int c = 0; c < 400; c++) begin
            acc = i_tvalid && o_tready;
            tick();
            i_r_ena = !i_r_ena;
            if (acc) begin
                sent++;
                if (sent < 32) i_tdata = 8'(sent);
                else i_tvalid = 1'b0;
            end
            if (sent == 32 && exp_q.size() == 0) break;
        end
        tick();
        check("toggle_all_sent", 32'(sent), 32'd32);
        check("toggle_drained", 32'(exp_q.size()), 32'd0);

        // 6: reset with bytes buffered and EOL pending
        i_r_ena = 1'b1;
        tick();
        push_byte(8'h54, 1'b1);
        tick();
        check("t_val", 32'({o_r_val, o_r_dat}), 32'h154);
        check("t_frames", 32'(o_frames), 32'd3);
        i_r_ena = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'(8'hC0 + i), 1'b0);
        tick();
        check("pre_rst_idle", 32'(o_r_val), 32'd0);
        i_rst_n = 1'b0;
        exp_q.delete();
        frames_exp = 16'h0000;
        tick();
        check("mid_rst_val", 32'(o_r_val), 32'd0);
        check("mid_rst_tready", 32'(o_tready), 32'd0);
        check("mid_rst_frames", 32'(o_frames), 32'd0);
        i_rst_n = 1'b1;
        i_r_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", 32'(o_r_val), 32'd0);
        end
        check("post_rst_tready", 32'(o_tready), 32'd1);
        i_tvalid = 1'b1;
        i_tdata  = 8'h33;
        tick();
        i_tvalid = 1'b0;
        tick();
        check("post_rst_byte", 32'({o_r_val, o_r_dat}), 32'h133);
        check("post_rst_frames", 32'(o_frames), 32'd0);
        tick();
        tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
